hazard_ctrl: RTL

Pipeline hazard controller for the 5-stage core. It watches the operand addresses of the instruction in decode and the destination fields leaving the ID/EX register. From these it drives:
- stall and bubble controls back into the front-end registers;
- forwarding selects that are latched into ID/EX alongside the instruction;
- a global freeze during data-cache misses.

It keeps its own registered shadow of the MEM and WB destination fields, plus a saturating stall counter for performance reporting.

---
 rtl/hazard_ctrl_if.sv | 41 ++++
 rtl/hazard_ctrl.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl_if.sv
// Signal bundle between the pipeline and the hazard controller.
// The pipeline side uses the master modport; hazard_ctrl uses the slave modport.
interface hazard_ctrl_if #(
    parameter int R_ADRESS_WIDTH = 5,
    parameter int CNT_WIDTH      = 16
);
    logic [R_ADRESS_WIDTH-1:0] id_rs1;
    logic [R_ADRESS_WIDTH-1:0] id_rs2;
    logic                      id_use_rs1;
    logic                      id_use_rs2;
    logic [R_ADRESS_WIDTH-1:0] ex_rd;
    logic                      ex_reg_write_en;
    logic                      ex_lw;
    logic                      ex_branch_taken;
    logic                      dmem_miss;
    logic                      dmem_ready;

    logic                      stall_if;
    logic                      bubble_id;
    logic                      flush_if;
    logic                      freeze;
    logic [1:0]                fwd_a_sel;
    logic [1:0]                fwd_b_sel;
    logic [CNT_WIDTH-1:0]      stall_count;

    modport master (
        output id_rs1, id_rs2, id_use_rs1, id_use_rs2,
        output ex_rd, ex_reg_write_en, ex_lw, ex_branch_taken,
        output dmem_miss, dmem_ready,
        input  stall_if, bubble_id, flush_if, freeze,
        input  fwd_a_sel, fwd_b_sel, stall_count
    );

    modport slave (
        input  id_rs1, id_rs2, id_use_rs1, id_use_rs2,
        input  ex_rd, ex_reg_write_en, ex_lw, ex_branch_taken,
        input  dmem_miss, dmem_ready,
        output stall_if, bubble_id, flush_if, freeze,
        output fwd_a_sel, fwd_b_sel, stall_count
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, branch flushes, operand
// forwarding selects and a global freeze while the data cache refills.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   RUN   | normal flow; a miss without same-cycle ready freezes now
//   MISS  | refill in progress; frozen until dmem_ready, which unfreezes
module hazard_ctrl #(
    parameter int R_ADRESS_WIDTH = 5,
    parameter int CNT_WIDTH      = 16
) (
    input logic          clk,
    input logic          rst,
    hazard_ctrl_if.slave bus
);
    typedef enum logic [0:0] {
        RUN  = 1'b0,
        MISS = 1'b1
    } state_t;

    state_t                    state;
    state_t                    next_state;
    logic                      miss_hold;

    logic [R_ADRESS_WIDTH-1:0] mem_rd;
    logic [R_ADRESS_WIDTH-1:0] wb_rd;
    logic                      mem_we;
    logic                      wb_we;
    logic [CNT_WIDTH-1:0]      stall_cnt;

    logic                      ex_a, mem_a, wb_a;
    logic                      ex_b, mem_b, wb_b;
    logic                      load_use;

    logic                      stall_c;
    logic                      bubble_c;
    logic                      flush_c;
    logic                      freeze_c;
    logic [1:0]                fwd_a_c;
    logic [1:0]                fwd_b_c;

    // x0 is hardwired to zero, so it never forms a dependency.
    function automatic logic src_match(input logic                      use_src,
                                       input logic                      prod_we,
                                       input logic [R_ADRESS_WIDTH-1:0] src,
                                       input logic [R_ADRESS_WIDTH-1:0] prod);
        return use_src && prod_we && (src == prod) && (src != '0);
    endfunction

    // Selects name where the producer will sit once the consumer reaches EX.
    function automatic logic [1:0] fwd_pick(input logic m_ex,
                                            input logic m_mem,
                                            input logic m_wb);
        if (m_ex)       return 2'b01;
        else if (m_mem) return 2'b10;
        else if (m_wb)  return 2'b11;
        else            return 2'b00;
    endfunction

    assign ex_a  = src_match(bus.id_use_rs1, bus.ex_reg_write_en, bus.id_rs1, bus.ex_rd);
    assign mem_a = src_match(bus.id_use_rs1, mem_we, bus.id_rs1, mem_rd);
    assign wb_a  = src_match(bus.id_use_rs1, wb_we, bus.id_rs1, wb_rd);
    assign ex_b  = src_match(bus.id_use_rs2, bus.ex_reg_write_en, bus.id_rs2, bus.ex_rd);
    assign mem_b = src_match(bus.id_use_rs2, mem_we, bus.id_rs2, mem_rd);
    assign wb_b  = src_match(bus.id_use_rs2, wb_we, bus.id_rs2, wb_rd);

    assign load_use = bus.ex_lw && (ex_a || ex_b);

    // Miss FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= RUN;
        else      state <= next_state;
    end

    // Miss FSM next state and raw freeze condition.
    always_comb begin
        next_state = state;
        miss_hold  = 1'b0;
        case (state)
            RUN: begin
                miss_hold = bus.dmem_miss && !bus.dmem_ready;
                if (miss_hold) next_state = MISS;
            end
            MISS: begin
                miss_hold = !bus.dmem_ready;
                if (bus.dmem_ready) next_state = RUN;
            end
            default: next_state = RUN;
        endcase
    end

    // Hazard outputs: freeze beats branch, branch beats load-use; all quiet in reset.
    always_comb begin
        stall_c  = 1'b0;
        bubble_c = 1'b0;
        flush_c  = 1'b0;
        freeze_c = 1'b0;
        fwd_a_c  = 2'b00;
        fwd_b_c  = 2'b00;
        if (rst) begin
            freeze_c = miss_hold;
            fwd_a_c  = fwd_pick(ex_a, mem_a, wb_a);
            fwd_b_c  = fwd_pick(ex_b, mem_b, wb_b);
            if (!miss_hold) begin
                if (bus.ex_branch_taken) begin
                    flush_c  = 1'b1;
                    bubble_c = 1'b1;
                end else if (load_use) begin
                    stall_c  = 1'b1;
                    bubble_c = 1'b1;
                end
            end
        end
    end

    assign bus.stall_if    = stall_c;
    assign bus.bubble_id   = bubble_c;
    assign bus.flush_if    = flush_c;
    assign bus.freeze      = freeze_c;
    assign bus.fwd_a_sel   = fwd_a_c;
    assign bus.fwd_b_sel   = fwd_b_c;
    assign bus.stall_count = stall_cnt;

    // Shadow of MEM/WB destinations; bubbles and flushed slots still advance.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_rd <= '0;
            mem_we <= 1'b0;
            wb_rd  <= '0;
            wb_we  <= 1'b0;
        end else if (!freeze_c) begin
            mem_rd <= bus.ex_rd;
            mem_we <= bus.ex_reg_write_en;
            wb_rd  <= mem_rd;
            wb_we  <= mem_we;
        end
    end

    // Saturating count of cycles lost to stalls or freezes.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt <= '0;
        end else if ((stall_c || freeze_c) && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
        end
    end
endmodule
